// File: rtl/card_dealer.sv
// Card shoe for the blackjack game: deals ranks 1..13 without replacement from
// DECKS x 52 cards, using a free-running 16-bit Galois LFSR to pick the starting rank.
module card_dealer #(
    parameter int          DECKS     = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shuffle,
    input  logic       deal_req,
    output logic [3:0] card,
    output logic       card_valid,
    output logic       busy,
    output logic       deal_err,
    output logic       deck_empty,
    output logic [7:0] cards_left
);
    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [4:0]  RANK_FULL = 5'(4 * DECKS);
    localparam logic [7:0]  SHOE_FULL = 8'(52 * DECKS);

    typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [4:0]  count [13];
    logic [3:0]  probe;
    logic [3:0]  start_rank;
    logic [3:0]  idx;

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ 16'hB400;
        end
    end

    assign start_rank = 4'(lfsr % 16'd13) + 4'd1;
    assign idx        = probe - 4'd1;
    assign busy       = (state == SEARCH);
    assign deck_empty = (cards_left == 8'd0);

    // The LFSR free-runs and is deliberately untouched by shuffle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            probe      <= 4'd1;
            card       <= 4'd0;
            card_valid <= 1'b0;
            deal_err   <= 1'b0;
            cards_left <= SHOE_FULL;
            for (int i = 0; i < 13; i++) begin
                count[i] <= RANK_FULL;
            end
        end else begin
            card_valid <= 1'b0;
            deal_err   <= 1'b0;
            if (shuffle) begin
                state      <= IDLE;
                card       <= 4'd0;
                cards_left <= SHOE_FULL;
                for (int i = 0; i < 13; i++) begin
                    count[i] <= RANK_FULL;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (deal_req) begin
                            if (cards_left != 8'd0) begin
                                probe <= start_rank;
                                state <= SEARCH;
                            end else begin
                                deal_err <= 1'b1;
                            end
                        end
                    end
                    SEARCH: begin
                        // Walk upward (13 wraps to 1) until a rank with cards remains.
                        if (count[idx] != 5'd0) begin
                            count[idx] <= count[idx] - 5'd1;
                            cards_left <= cards_left - 8'd1;
                            card       <= probe;
                            card_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            probe <= (probe == 4'd13) ? 4'd1 : probe + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: one DECKS=1 instance and one DECKS=4 instance,
// checked against a per-rank shoe model kept in the bench.
module tb_card_dealer;
    logic            clk;
    logic [1:0]      rst_n_v;
    logic [1:0]      shuffle_v;
    logic [1:0]      deal_req_v;
    logic [1:0][3:0] card_v;
    logic [1:0]      card_valid_v;
    logic [1:0]      busy_v;
    logic [1:0]      deal_err_v;
    logic [1:0]      deck_empty_v;
    logic [1:0][7:0] left_v;

    int          n_cmp;
    int          n_err;
    int          sel;
    int          exp_cnt [2][14];
    int          seen    [2][14];
    int          exp_left[2];
    logic [7:0]  exp_q[$];

    card_dealer #(.DECKS(1)) dut (
        .clk(clk), .rst_n(rst_n_v[0]), .shuffle(shuffle_v[0]), .deal_req(deal_req_v[0]),
        .card(card_v[0]), .card_valid(card_valid_v[0]), .busy(busy_v[0]),
        .deal_err(deal_err_v[0]), .deck_empty(deck_empty_v[0]), .cards_left(left_v[0])
    );

    card_dealer #(.DECKS(4)) dut4 (
        .clk(clk), .rst_n(rst_n_v[1]), .shuffle(shuffle_v[1]), .deal_req(deal_req_v[1]),
        .card(card_v[1]), .card_valid(card_valid_v[1]), .busy(busy_v[1]),
        .deal_err(deal_err_v[1]), .deck_empty(deck_empty_v[1]), .cards_left(left_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int decks_of(input int s);
        return (s == 0) ? 1 : 4;
    endfunction

    task automatic refill_model(input int s);
        for (int r = 1; r <= 13; r++) begin
            exp_cnt[s][r] = 4 * decks_of(s);
            seen[s][r]    = 0;
        end
        exp_left[s] = 52 * decks_of(s);
    endtask

    // Called at a negedge with a non-empty shoe; returns the card and the
    // number of negedges from request to card_valid.
    task automatic deal_one(output logic [3:0] c, output int lat);
        bit got;
        deal_req_v[sel] = 1'b1;
        @(negedge clk);
        deal_req_v[sel] = 1'b0;
        check("busy_after_accept", busy_v[sel], 1);
        lat = 1;
        got = 1'b0;
        c   = 4'd0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (card_valid_v[sel]) begin
                got = 1'b1;
                c   = card_v[sel];
            end
        end
        check("deal_timeout", got, 1);
        check("deal_latency", (lat >= 2 && lat <= 14), 1);
        check("busy_drops_with_valid", busy_v[sel], 0);
    endtask

    task automatic deal_and_score(output logic [3:0] c);
        int lat;
        exp_q.push_back(8'(exp_left[sel] - 1));
        deal_one(c, lat);
        check("card_range", (c >= 1 && c <= 13), 1);
        if (c >= 1 && c <= 13) begin
            check("rank_available", (exp_cnt[sel][c] > 0), 1);
            if (exp_cnt[sel][c] > 0) exp_cnt[sel][c]--;
            seen[sel][c]++;
        end
        exp_left[sel]--;
        check("cards_left", left_v[sel], int'(exp_q.pop_front()));
        check("deck_empty", deck_empty_v[sel], (exp_left[sel] == 0));
    endtask

    task automatic full_deal(input int total);
        logic [3:0] c;
        int         last_r;
        for (int i = 0; i < total; i++) begin
            last_r = 0;
            if (i == total - 1) begin
                for (int r = 1; r <= 13; r++) begin
                    if (exp_cnt[sel][r] == 1) last_r = r;
                end
            end
            deal_and_score(c);
            if (i == total - 1) check("forced_last_card", c, last_r);
        end
        for (int r = 1; r <= 13; r++) begin
            check("rank_seen_count", seen[sel][r], total / 13);
        end
    endtask

    task automatic reset_mid_search(input int full);
        deal_req_v[sel] = 1'b1;
        @(negedge clk);
        deal_req_v[sel] = 1'b0;
        check("mid_search_busy", busy_v[sel], 1);
        #2 rst_n_v[sel] = 1'b0;
        #1;
        check("rst_busy", busy_v[sel], 0);
        check("rst_card", card_v[sel], 0);
        check("rst_card_valid", card_valid_v[sel], 0);
        check("rst_deal_err", deal_err_v[sel], 0);
        check("rst_deck_empty", deck_empty_v[sel], 0);
        check("rst_cards_left", left_v[sel], full);
        @(negedge clk);
        rst_n_v[sel] = 1'b1;
        refill_model(sel);
        repeat (2) @(negedge clk);
        check("rst_no_valid_after", card_valid_v[sel], 0);
    endtask

    initial begin
        logic [3:0] c;
        int         lat;
        int         pulses;
        n_cmp = 0;
        n_err = 0;
        sel   = 0;
        rst_n_v    = 2'b00;
        shuffle_v  = 2'b00;
        deal_req_v = 2'b00;
        refill_model(0);
        refill_model(1);
        repeat (3) @(negedge clk);
        rst_n_v = 2'b11;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            check("reset_card", card_v[s], 0);
            check("reset_card_valid", card_valid_v[s], 0);
            check("reset_busy", busy_v[s], 0);
            check("reset_deal_err", deal_err_v[s], 0);
            check("reset_deck_empty", deck_empty_v[s], 0);
            check("reset_cards_left", left_v[s], 52 * decks_of(s));
        end

        // Full DECKS=1 deal, last card forced to the only remaining rank.
        full_deal(52);

        // Request against an empty shoe.
        deal_req_v[0] = 1'b1;
        @(negedge clk);
        deal_req_v[0] = 1'b0;
        check("empty_deal_err", deal_err_v[0], 1);
        check("empty_no_valid", card_valid_v[0], 0);
        check("empty_not_busy", busy_v[0], 0);
        @(negedge clk);
        check("empty_deal_err_pulse", deal_err_v[0], 0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (card_valid_v[0]) pulses++;
        end
        check("empty_valid_pulses", pulses, 0);
        check("empty_cards_left", left_v[0], 0);

        shuffle_v[0] = 1'b1;
        @(negedge clk);
        shuffle_v[0] = 1'b0;
        check("shuffle_cards_left", left_v[0], 52);
        check("shuffle_deck_empty", deck_empty_v[0], 0);
        check("shuffle_card", card_v[0], 0);
        refill_model(0);

        // Request held over two edges: exactly one card.
        deal_req_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        deal_req_v[0] = 1'b0;
        pulses = card_valid_v[0] ? 1 : 0;
        repeat (20) begin
            @(negedge clk);
            if (card_valid_v[0]) pulses++;
        end
        check("busy_drop_pulses", pulses, 1);
        check("busy_drop_cards_left", left_v[0], 51);

        // Shuffle on the cycle after accept aborts the search.
        deal_req_v[0] = 1'b1;
        @(negedge clk);
        deal_req_v[0] = 1'b0;
        shuffle_v[0]  = 1'b1;
        @(negedge clk);
        shuffle_v[0]  = 1'b0;
        check("abort_busy", busy_v[0], 0);
        check("abort_cards_left", left_v[0], 52);
        check("abort_card", card_v[0], 0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (card_valid_v[0]) pulses++;
        end
        check("abort_valid_pulses", pulses, 0);
        refill_model(0);

        deal_and_score(c);
        reset_mid_search(52);

        // DECKS=4 instance.
        sel = 1;
        deal_and_score(c);
        reset_mid_search(208);
        full_deal(208);

        sel = 0;
        deal_one(c, lat);
        check("post_reset_deal_left", left_v[0], 51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
